// File: rtl/cpc_cen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cpc_cen_sequencer
//  Description : Clock-enable sequencer for GA40010/UM6845R models. From one
//                fast clk it produces the 16 MHz tick (cen_16), a 16-tick phase
//                index, PHI (CPU) and CCLK (CRTC) edge enables. Supports a
//                runtime divisor, CPU turbo (8 MHz PHI) and glitch-free pause.
//                Optional macro CEN_SEQ_SYNC_EN adds the sync_in realign strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpc_cen_sequencer #(
  parameter int DIV_W     = 4,
  parameter int DIV_RESET = 4
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic [DIV_W-1:0] div_sel,
  input  logic             turbo,
  input  logic             pause,
`ifdef CEN_SEQ_SYNC_EN
  input  logic             sync_in,
`endif
  output logic             cen_16,
  output logic [3:0]       tick,
  output logic             phi_en_p,
  output logic             phi_en_n,
  output logic             phi_n,
  output logic             cclk_en_p,
  output logic             cclk_en_n,
  output logic             cclk,
  output logic             running
);

  localparam logic [DIV_W-1:0] C_DIV_RESET = DIV_W'(DIV_RESET);
  localparam logic [DIV_W-1:0] C_DIV_MIN   = DIV_W'(2);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic [3:0]       tick_q,    tick_d;
  logic             turbo_q,   turbo_d;
  logic             cen_q,     cen_d;
  logic             phi_p_q,   phi_p_d;
  logic             phi_nn_q,  phi_nn_d;
  logic             phi_n_q,   phi_n_d;
  logic             cclk_p_q,  cclk_p_d;
  logic             cclk_n_q,  cclk_n_d;
  logic             cclk_q,    cclk_d;
  logic             run_q,     run_d;

  logic [DIV_W-1:0] div_clamp;
  logic [DIV_W-1:0] div_last;
  logic [3:0]       tick_inc;

  // Divisor request clamp (0/1 are meaningless), wrap point and next index.
  assign div_clamp = (div_sel < C_DIV_MIN) ? C_DIV_MIN : div_sel;
  assign div_last  = div_q - DIV_W'(1);
  assign tick_inc  = tick_q + 4'd1;

  // Next-state: tick issue at divider wrap, pause hold, optional realign.
  always_comb begin
    div_cnt_d = div_cnt_q;
    div_d     = div_q;
    tick_d    = tick_q;
    turbo_d   = turbo_q;
    cen_d     = 1'b0;
    phi_p_d   = 1'b0;
    phi_nn_d  = 1'b0;
    phi_n_d   = phi_n_q;
    cclk_p_d  = 1'b0;
    cclk_n_d  = 1'b0;
    cclk_d    = cclk_q;
    run_d     = run_q;

    if (div_cnt_q == '0) begin
      if (pause) begin
        // Frozen at a tick boundary: counter parks at 0, levels hold.
        run_d = 1'b0;
      end else begin
        run_d     = 1'b1;
        cen_d     = 1'b1;
        tick_d    = tick_inc;
        // div_q is always >= 2, so the counter leaves 0 after a tick.
        div_cnt_d = DIV_W'(1);
        if (turbo_q) begin
          phi_p_d  = ~tick_inc[0];
          phi_nn_d = tick_inc[0];
        end else begin
          phi_p_d  = (tick_inc[1:0] == 2'd0);
          phi_nn_d = (tick_inc[1:0] == 2'd2);
        end
        if (phi_p_d)  phi_n_d = 1'b0;
        if (phi_nn_d) phi_n_d = 1'b1;
        cclk_p_d = (tick_inc == 4'd0);
        cclk_n_d = (tick_inc == 4'd8);
        if (cclk_p_d) cclk_d = 1'b1;
        if (cclk_n_d) cclk_d = 1'b0;
        // Reconfiguration only at the frame's last tick so a frame is never
        // stretched or shortened mid-way.
        if (tick_inc == 4'd15) begin
          div_d   = div_clamp;
          turbo_d = turbo;
        end
      end
    end else begin
      div_cnt_d = (div_cnt_q >= div_last) ? '0 : div_cnt_q + DIV_W'(1);
    end

`ifdef CEN_SEQ_SYNC_EN
    if (sync_in) begin
      div_cnt_d = '0;
      tick_d    = 4'd15;
      div_d     = div_q;
      turbo_d   = turbo_q;
      cen_d     = 1'b0;
      phi_p_d   = 1'b0;
      phi_nn_d  = 1'b0;
      phi_n_d   = 1'b1;
      cclk_p_d  = 1'b0;
      cclk_n_d  = 1'b0;
      cclk_d    = 1'b0;
      run_d     = run_q;
    end
`endif
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      div_cnt_q <= '0;
      div_q     <= C_DIV_RESET;
      tick_q    <= 4'd15;
      turbo_q   <= 1'b0;
      cen_q     <= 1'b0;
      phi_p_q   <= 1'b0;
      phi_nn_q  <= 1'b0;
      phi_n_q   <= 1'b1;
      cclk_p_q  <= 1'b0;
      cclk_n_q  <= 1'b0;
      cclk_q    <= 1'b0;
      run_q     <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      turbo_q   <= turbo_d;
      cen_q     <= cen_d;
      phi_p_q   <= phi_p_d;
      phi_nn_q  <= phi_nn_d;
      phi_n_q   <= phi_n_d;
      cclk_p_q  <= cclk_p_d;
      cclk_n_q  <= cclk_n_d;
      cclk_q    <= cclk_d;
      run_q     <= run_d;
    end
  end

  assign cen_16    = cen_q;
  assign tick      = tick_q;
  assign phi_en_p  = phi_p_q;
  assign phi_en_n  = phi_nn_q;
  assign phi_n     = phi_n_q;
  assign cclk_en_p = cclk_p_q;
  assign cclk_en_n = cclk_n_q;
  assign cclk      = cclk_q;
  assign running   = run_q;

endmodule
`default_nettype wire

// File: tb/tb_cpc_cen_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpc_cen_sequencer
//  Description : Randomized scoreboard bench for cpc_cen_sequencer. A
//                time-based event model predicts each cen_16 pulse (edge
//                number and payload); a monitor checks every edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpc_cen_sequencer;

  localparam int DIV_W     = 4;
  localparam int DIV_RESET = 4;
  localparam int N_EDGES   = 5000;

  typedef struct {
    int         t;
    logic [3:0] tk;
    logic       pp, pn, phn, cp, cn, ck;
  } exp_t;

  logic             clk = 1'b0;
  logic             RESET_N;
  logic [DIV_W-1:0] div_sel;
  logic             turbo;
  logic             pause;
  logic             sync_in;
  logic             cen_16, phi_en_p, phi_en_n, phi_n;
  logic             cclk_en_p, cclk_en_n, cclk, running;
  logic [3:0]       tick;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;
  exp_t q[$];

  // Model state: tick index, active divisor/turbo, edge at which the next
  // tick is due, and the expected output levels after the latest edge.
  int m_tick, m_div, m_due;
  bit m_turbo, m_phi_n, m_cclk, m_run;
  bit m_valid = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpc_cen_sequencer #(.DIV_W(DIV_W), .DIV_RESET(DIV_RESET)) dut (
    .clk       (clk),
    .RESET_N   (RESET_N),
    .div_sel   (div_sel),
    .turbo     (turbo),
    .pause     (pause),
`ifdef CEN_SEQ_SYNC_EN
    .sync_in   (sync_in),
`endif
    .cen_16    (cen_16),
    .tick      (tick),
    .phi_en_p  (phi_en_p),
    .phi_en_n  (phi_en_n),
    .phi_n     (phi_n),
    .cclk_en_p (cclk_en_p),
    .cclk_en_n (cclk_en_n),
    .cclk      (cclk),
    .running   (running)
  );

  // Predict the effect of clock edge e given the inputs now applied.
  task automatic model_step(input int e);
    exp_t x;
    bit   pp, pn;
    if (!RESET_N) begin
      m_valid = 1; m_tick = 15; m_div = DIV_RESET; m_turbo = 0;
      m_due = e + 1; m_phi_n = 1; m_cclk = 0; m_run = 1;
      return;
    end
    if (!m_valid) return;
`ifdef CEN_SEQ_SYNC_EN
    if (sync_in) begin
      m_tick = 15; m_due = e + 1; m_phi_n = 1; m_cclk = 0;
      return;
    end
`endif
    if (e < m_due) return;
    if (pause) begin
      m_run = 0;
      return;
    end
    m_run  = 1;
    m_tick = (m_tick + 1) % 16;
    pp = m_turbo ? (m_tick % 2 == 0) : (m_tick % 4 == 0);
    pn = m_turbo ? (m_tick % 2 == 1) : (m_tick % 4 == 2);
    if (pp) m_phi_n = 0;
    if (pn) m_phi_n = 1;
    if (m_tick == 0) m_cclk = 1;
    if (m_tick == 8) m_cclk = 0;
    x.t = e; x.tk = 4'(m_tick); x.pp = pp; x.pn = pn; x.phn = m_phi_n;
    x.cp = (m_tick == 0); x.cn = (m_tick == 8); x.ck = m_cclk;
    q.push_back(x);
    if (m_tick == 15) begin
      m_div   = (int'(div_sel) < 2) ? 2 : int'(div_sel);
      m_turbo = turbo;
    end
    m_due = e + m_div;
  endtask

  // Stimulus: a clean opening stretch, then random divisor/turbo/pause/reset.
  initial begin
    int pause_left = 0;
    int rst_left   = 3;
    RESET_N = 1'b0; div_sel = 4'd4; turbo = 1'b0; pause = 1'b0; sync_in = 1'b0;
    for (int k = 0; k < N_EDGES; k++) begin
      if (k >= 200) begin
        if ($urandom_range(0, 699) == 0) rst_left = 1;
        if ($urandom_range(0, 39) == 0) div_sel = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 59) == 0) turbo = ~turbo;
`ifdef CEN_SEQ_SYNC_EN
        sync_in = ($urandom_range(0, 249) == 0);
`endif
        if (pause_left > 0) begin
          pause = 1'b1;
          pause_left--;
        end else begin
          pause = 1'b0;
          if ($urandom_range(0, 79) == 0) pause_left = $urandom_range(1, 25);
        end
      end
      if (rst_left > 0) begin
        RESET_N = 1'b0;
        rst_left--;
      end else begin
        RESET_N = 1'b1;
      end
      model_step(cyc + 1);
      @(negedge clk);
    end
    done = 1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d predicted pulses never seen, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: after each edge, match a due prediction or check idle levels.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (m_valid) begin
        bit   exp_c;
        exp_t x;
        exp_c = (q.size() > 0) && (q[0].t == cyc);
        checks++;
        if (cen_16 !== exp_c) begin
          errors++;
          $display("FAIL cen_16 @edge %0d: got %b required %b", cyc, cen_16, exp_c);
        end
        if (exp_c) begin
          x = q.pop_front();
          checks++;
          if ({tick, phi_en_p, phi_en_n, phi_n, cclk_en_p, cclk_en_n, cclk, running} !==
              {x.tk, x.pp, x.pn, x.phn, x.cp, x.cn, x.ck, 1'b1}) begin
            errors++;
            $display("FAIL pulse @edge %0d: got tick=%0d pp=%b pn=%b phin=%b cp=%b cn=%b ck=%b run=%b required tick=%0d pp=%b pn=%b phin=%b cp=%b cn=%b ck=%b run=1",
                     cyc, tick, phi_en_p, phi_en_n, phi_n, cclk_en_p, cclk_en_n, cclk, running,
                     x.tk, x.pp, x.pn, x.phn, x.cp, x.cn, x.ck);
          end
        end else begin
          checks++;
          if ({phi_en_p, phi_en_n, cclk_en_p, cclk_en_n, phi_n, cclk, running, tick} !==
              {4'b0000, m_phi_n, m_cclk, m_run, 4'(m_tick)}) begin
            errors++;
            $display("FAIL idle @edge %0d: got en=%b%b%b%b phin=%b ck=%b run=%b tick=%0d required en=0000 phin=%b ck=%b run=%b tick=%0d",
                     cyc, phi_en_p, phi_en_n, cclk_en_p, cclk_en_n, phi_n, cclk, running, tick,
                     m_phi_n, m_cclk, m_run, m_tick);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
